// File: rtl/alu_control_mdu_pkg.sv
// Shared encodings for the ALU control decoder and its iterative multiply/divide unit:
// ALUOp classes, ALUCtrl codes, funct codes and the MDU state encoding.
package alu_ctrl_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [3:0] ALUC_AND  = 4'b0000;
    localparam logic [3:0] ALUC_OR   = 4'b0001;
    localparam logic [3:0] ALUC_ADD  = 4'b0010;
    localparam logic [3:0] ALUC_XOR  = 4'b0011;
    localparam logic [3:0] ALUC_SLTU = 4'b0101;
    localparam logic [3:0] ALUC_SUB  = 4'b0110;
    localparam logic [3:0] ALUC_SLT  = 4'b0111;
    localparam logic [3:0] ALUC_SLL  = 4'b1000;
    localparam logic [3:0] ALUC_SRL  = 4'b1001;
    localparam logic [3:0] ALUC_SRA  = 4'b1010;
    localparam logic [3:0] ALUC_NOR  = 4'b1100;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } mdu_state_e;

    function automatic logic is_mdu_funct(input logic [5:0] f);
        return (f[5:2] == 4'b0110) || (f[5:2] == 4'b0100);
    endfunction

endpackage

// File: rtl/alu_control_mdu_if.sv
// Core-to-decoder bundle: the core (master) presents the instruction fields and operands,
// the decoder (slave) returns ALU control, stall and HI/LO state.
interface alu_control_mdu_if #(
    parameter int DATA_W    = 32,
    parameter int ALUCTRL_W = 4
) ();
    import alu_ctrl_pkg::*;

    // issue qualifies the instruction fields for one cycle; an MDU instruction that sees
    // stall high that cycle has no effect and must be presented again.
    logic                 issue;
    logic [1:0]           ALUOp;
    logic [5:0]           funct;
    logic [DATA_W-1:0]    op_a;
    logic [DATA_W-1:0]    op_b;
    logic [ALUCTRL_W-1:0] ALUCtrl;
    logic                 Jr;
    logic                 stall;
    logic [DATA_W-1:0]    mf_data;
    logic                 mdu_busy;
    logic [DATA_W-1:0]    hi;
    logic [DATA_W-1:0]    lo;
    mdu_state_e           mdu_state;

    modport master (
        output issue, ALUOp, funct, op_a, op_b,
        input  ALUCtrl, Jr, stall, mf_data, mdu_busy, hi, lo, mdu_state
    );

    modport slave (
        input  issue, ALUOp, funct, op_a, op_b,
        output ALUCtrl, Jr, stall, mf_data, mdu_busy, hi, lo, mdu_state
    );

endinterface

// File: rtl/alu_control_mdu_iter.sv
// Iterative multiply/divide engine with HI/LO. Define MDU_EARLY_TERM_EN to let MUL
// finish as soon as the remaining multiplier bits are all zero.
module mdu_iter
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_mul_i,
    input  logic              start_div_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] op_a_i,
    input  logic [DATA_W-1:0] op_b_i,
    input  logic              wr_hi_i,
    input  logic              wr_lo_i,
    output logic              busy_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output mdu_state_e        state_o
);

    localparam int CNT_W = $clog2(DATA_W);

    mdu_state_e          state_q;
    logic                busy_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2*DATA_W-1:0] acc_q, mcand_q;
    logic [DATA_W-1:0]   mplier_q;
    logic [DATA_W-1:0]   rem_q, quo_q, dvsr_q;
    logic                neg_lo_q, neg_hi_q, is_div_q, dz_q;
    logic [DATA_W-1:0]   hi_q, lo_q;

    logic                a_neg, b_neg;
    logic [DATA_W-1:0]   a_mag, b_mag;
    logic [2*DATA_W-1:0] acc_d, prod_fix;
    logic [DATA_W:0]     rem_sh, rem_d;
    logic                quo_bit;
    logic [DATA_W-1:0]   quo_d, quo_fix, rem_fix;
    logic                mul_done;

    // Signed operands are iterated as magnitudes; the most-negative value maps onto itself,
    // which is still the correct magnitude when read unsigned.
    always_comb begin
        a_neg = signed_i & op_a_i[DATA_W-1];
        b_neg = signed_i & op_b_i[DATA_W-1];
        a_mag = a_neg ? (~op_a_i + 1'b1) : op_a_i;
        b_mag = b_neg ? (~op_b_i + 1'b1) : op_b_i;
    end

    always_comb begin
        acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        rem_sh   = {rem_q, quo_q[DATA_W-1]};
        quo_bit  = (rem_sh >= {1'b0, dvsr_q});
        rem_d    = quo_bit ? (rem_sh - {1'b0, dvsr_q}) : rem_sh;
        quo_d    = {quo_q[DATA_W-2:0], quo_bit};
        prod_fix = neg_lo_q ? (~acc_q + 1'b1) : acc_q;
        quo_fix  = neg_lo_q ? (~quo_q + 1'b1) : quo_q;
        rem_fix  = neg_hi_q ? (~rem_q + 1'b1) : rem_q;
`ifdef MDU_EARLY_TERM_EN
        mul_done = (cnt_q == '0) || (mplier_q[DATA_W-1:1] == '0);
`else
        mul_done = (cnt_q == '0);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            is_div_q <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_mul_i) begin
                        acc_q    <= '0;
                        mcand_q  <= {{DATA_W{1'b0}}, b_mag};
                        mplier_q <= a_mag;
                        neg_lo_q <= a_neg ^ b_neg;
                        is_div_q <= 1'b0;
                        dz_q     <= 1'b0;
                        cnt_q    <= CNT_W'(DATA_W - 1);
                        busy_q   <= 1'b1;
                        state_q  <= ST_MUL;
                    end else if (start_div_i) begin
                        is_div_q <= 1'b1;
                        busy_q   <= 1'b1;
                        if (op_b_i == '0) begin
                            // Divide by zero skips iteration; quo_q carries raw op_a to HI.
                            dz_q    <= 1'b1;
                            quo_q   <= op_a_i;
                            state_q <= ST_FIX;
                        end else begin
                            dz_q     <= 1'b0;
                            rem_q    <= '0;
                            quo_q    <= a_mag;
                            dvsr_q   <= b_mag;
                            neg_lo_q <= a_neg ^ b_neg;
                            neg_hi_q <= a_neg;
                            cnt_q    <= CNT_W'(DATA_W - 1);
                            state_q  <= ST_DIV;
                        end
                    end else begin
                        if (wr_hi_i) hi_q <= op_a_i;
                        if (wr_lo_i) lo_q <= op_a_i;
                    end
                end
                ST_MUL: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - 1'b1;
                    if (mul_done) state_q <= ST_FIX;
                end
                ST_DIV: begin
                    rem_q <= rem_d[DATA_W-1:0];
                    quo_q <= quo_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) state_q <= ST_FIX;
                end
                ST_FIX: begin
                    if (dz_q) begin
                        lo_q <= '1;
                        hi_q <= quo_q;
                    end else if (is_div_q) begin
                        lo_q <= quo_fix;
                        hi_q <= rem_fix;
                    end else begin
                        {hi_q, lo_q} <= prod_fix;
                    end
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o  = busy_q;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;
    assign state_o = state_q;

endmodule

// File: rtl/alu_control_mdu.sv
// ALU control decoder with an attached iterative MDU: decode, Jr, stall and mf_data live here.
// Optional MDU_EARLY_TERM_EN shortens multiplies whose multiplier runs out of set bits.
module alu_control_mdu
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ALUCTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_control_mdu_if.slave  bus
);

    logic [3:0]        code4;
    logic              is_mdu, go, busy;
    logic              start_mul, start_div, wr_hi, wr_lo;
    logic [DATA_W-1:0] hi_w, lo_w;
    mdu_state_e        state_w;

    always_comb begin
        code4 = ALUC_ADD;
        case (bus.ALUOp)
            ALUOP_ADD: code4 = ALUC_ADD;
            ALUOP_SUB: code4 = ALUC_SUB;
            ALUOP_OR:  code4 = ALUC_OR;
            default: begin
                case (bus.funct)
                    FN_ADD, FN_ADDU: code4 = ALUC_ADD;
                    FN_SUB, FN_SUBU: code4 = ALUC_SUB;
                    FN_AND:          code4 = ALUC_AND;
                    FN_OR:           code4 = ALUC_OR;
                    FN_XOR:          code4 = ALUC_XOR;
                    FN_NOR:          code4 = ALUC_NOR;
                    FN_SLT:          code4 = ALUC_SLT;
                    FN_SLTU:         code4 = ALUC_SLTU;
                    FN_SLL:          code4 = ALUC_SLL;
                    FN_SRL:          code4 = ALUC_SRL;
                    FN_SRA:          code4 = ALUC_SRA;
                    default:         code4 = ALUC_ADD;
                endcase
            end
        endcase
    end

    // MDU instructions only act when the engine is idle; otherwise they stall and retry.
    always_comb begin
        is_mdu    = (bus.ALUOp == ALUOP_RTYPE) && is_mdu_funct(bus.funct);
        go        = bus.issue && is_mdu && !busy;
        start_mul = go && ((bus.funct == FN_MULT) || (bus.funct == FN_MULTU));
        start_div = go && ((bus.funct == FN_DIV)  || (bus.funct == FN_DIVU));
        wr_hi     = go && (bus.funct == FN_MTHI);
        wr_lo     = go && (bus.funct == FN_MTLO);
    end

    mdu_iter #(.DATA_W(DATA_W)) u_mdu (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_mul_i (start_mul),
        .start_div_i (start_div),
        .signed_i    (~bus.funct[0]),
        .op_a_i      (bus.op_a),
        .op_b_i      (bus.op_b),
        .wr_hi_i     (wr_hi),
        .wr_lo_i     (wr_lo),
        .busy_o      (busy),
        .hi_o        (hi_w),
        .lo_o        (lo_w),
        .state_o     (state_w)
    );

    assign bus.ALUCtrl   = ALUCTRL_W'(code4);
    assign bus.Jr        = (bus.ALUOp == ALUOP_RTYPE) && (bus.funct == FN_JR);
    assign bus.stall     = bus.issue && is_mdu && busy;
    assign bus.mf_data   = bus.funct[1] ? lo_w : hi_w;
    assign bus.mdu_busy  = busy;
    assign bus.hi        = hi_w;
    assign bus.lo        = lo_w;
    assign bus.mdu_state = state_w;

endmodule
